// File: rtl/texture_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : texture_pkg                                              |
// | Description : Shared constants, FSM state encoding and beat-count      |
// |               helpers for the ping-pong texture upload controller.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package texture_pkg;

  // One-hot upload modes as presented on cmd_mode
  localparam logic [3:0] TEX_MODE_32  = 4'b0001;
  localparam logic [3:0] TEX_MODE_64  = 4'b0010;
  localparam logic [3:0] TEX_MODE_128 = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_SWAP = 2'd2,
    ST_DRAIN     = 2'd3
  } tex_state_t;

  // Beats needed to carry one texture of 16-bit texels; 0 for unsupported modes
  function automatic int unsigned tex_beats(input logic [3:0] mode,
                                            input int unsigned stream_width);
    int unsigned side;
    case (mode)
      TEX_MODE_32:  side = 32;
      TEX_MODE_64:  side = 64;
      TEX_MODE_128: side = 128;
      default:      side = 0;
    endcase
    return (side * side * 16) / stream_width;
  endfunction

  function automatic logic tex_mode_ok(input logic [3:0] mode);
    return (mode == TEX_MODE_32) || (mode == TEX_MODE_64) || (mode == TEX_MODE_128);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tex_beat_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tex_beat_counter                                         |
// | Description : Beat counter with a loadable terminal value. o_tc is     |
// |               high while the count equals the loaded last-beat index.  |
// | Revision    : 1.0 - initial release                                    |
// | Ports       : clk, reset   - clock, synchronous active-high reset      |
// |               i_load       - capture i_last_val as the terminal index  |
// |               i_last_val   - index of the final beat (BEATS-1)         |
// |               i_clear      - return count to 0 (priority over i_inc)   |
// |               i_inc        - advance count by one                      |
// |               o_cnt, o_tc  - current count, terminal-count flag        |
// +------------------------------------------------------------------------+
module tex_beat_counter #(
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_last_val,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_last <= '0;
    end else begin
      if (i_load)
        r_last <= i_last_val;
      if (i_clear)
        r_cnt <= '0;
      else if (i_inc)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == r_last);

endmodule
`default_nettype wire

// File: rtl/texture_upload_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : texture_upload_ctrl                                      |
// | Description : Streams one texture per command into the shadow bank of  |
// |               a ping-pong texture buffer, generates the bank tlast at  |
// |               the exact beat count and swaps banks only while the      |
// |               rasterizer is idle.                                      |
// | Revision    : 1.0 - initial release                                    |
// | Config      : TEXTURE_LEN_CHECK_EN - compare upstream tlast against    |
// |               the expected length; flag err and drain/abort on a       |
// |               mismatch. Without it tlast is ignored and err is 0.      |
// | Ports       : cmd_valid/ready/mode   - upload command (one-hot mode)   |
// |               s_axis_*               - upstream texel stream           |
// |               m0_axis_*, m1_axis_*   - bank write streams              |
// |               raster_busy            - rasterizer reading active bank  |
// |               active_bank/mode       - texel read mux selection        |
// |               upload_done            - one-cycle pulse on bank swap    |
// |               err                    - sticky length/mode error        |
// +------------------------------------------------------------------------+
module texture_upload_ctrl
  import texture_pkg::*;
#(
  parameter int STREAM_WIDTH = 16,
  parameter int SIZE         = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_mode,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
  output logic                    m0_axis_tvalid,
  output logic                    m0_axis_tlast,
  output logic [STREAM_WIDTH-1:0] m0_axis_tdata,
  output logic                    m1_axis_tvalid,
  output logic                    m1_axis_tlast,
  output logic [STREAM_WIDTH-1:0] m1_axis_tdata,
  input  logic                    raster_busy,
  output logic                    active_bank,
  output logic [3:0]              active_mode,
  output logic                    upload_done,
  output logic                    err
);

  localparam int unsigned MAX_BEATS = tex_beats(TEX_MODE_128, STREAM_WIDTH);
  localparam int          CNT_W     = $clog2(MAX_BEATS) + 1;

  // The largest texture's beat count has to fit in a bank
  generate
    if (MAX_BEATS > (1 << SIZE)) begin : g_size_check
      $error("texture_upload_ctrl: largest texture does not fit in a bank");
    end
  endgenerate

  tex_state_t       r_state;
  logic             r_active_bank;
  logic [3:0]       r_active_mode;
  logic [3:0]       r_pending_mode;
  logic             r_upload_done;
  logic             w_shadow;
  logic             w_accept;
  logic             w_mode_ok;
  logic             w_beat;
  logic             w_tc;
  logic             w_early;
  logic             w_bank_last;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_last_val;

  assign w_shadow   = ~r_active_bank;
  assign w_mode_ok  = tex_mode_ok(cmd_mode);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_beat     = (r_state == ST_LOAD) && s_axis_tvalid;
  assign w_last_val = CNT_W'(tex_beats(cmd_mode, STREAM_WIDTH) - 1);

`ifdef TEXTURE_LEN_CHECK_EN
  logic r_err;
  // Upstream ended the texture before the expected beat count
  assign w_early = w_beat && s_axis_tlast && !w_tc;
  assign err     = r_err;
`else
  logic w_unused_tlast;
  assign w_unused_tlast = s_axis_tlast;
  assign w_early        = 1'b0;
  assign err            = 1'b0;
`endif

  assign w_bank_last = w_beat && (w_tc || w_early);

  tex_beat_counter #(
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept && w_mode_ok),
    .i_last_val (w_last_val),
    .i_clear    (w_bank_last),
    .i_inc      (w_beat),
    .o_cnt      (w_cnt),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_active_bank  <= 1'b0;
      r_active_mode  <= 4'b0000;
      r_pending_mode <= 4'b0000;
      r_upload_done  <= 1'b0;
`ifdef TEXTURE_LEN_CHECK_EN
      r_err          <= 1'b0;
`endif
    end else begin
      r_upload_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_mode_ok) begin
              r_pending_mode <= cmd_mode;
              r_state        <= ST_LOAD;
            end
`ifdef TEXTURE_LEN_CHECK_EN
            else begin
              r_err <= 1'b1;
            end
`endif
          end
        end
        ST_LOAD: begin
          if (w_bank_last) begin
`ifdef TEXTURE_LEN_CHECK_EN
            if (w_early) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else if (!s_axis_tlast) begin
              // Expected length reached but upstream keeps going: discard the rest
              r_err   <= 1'b1;
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_WAIT_SWAP;
            end
`else
            r_state <= ST_WAIT_SWAP;
`endif
          end
        end
        ST_WAIT_SWAP: begin
          if (!raster_busy) begin
            r_active_bank <= ~r_active_bank;
            r_active_mode <= r_pending_mode;
            r_upload_done <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (s_axis_tvalid && s_axis_tlast)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Holding off cmd_ready during the upload_done cycle keeps a new command
  // from overlapping the swap pulse.
  assign cmd_ready      = (r_state == ST_IDLE) && !r_upload_done;
  assign s_axis_tready  = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
  assign m0_axis_tvalid = w_beat && !w_shadow;
  assign m1_axis_tvalid = w_beat && w_shadow;
  assign m0_axis_tlast  = w_bank_last && !w_shadow;
  assign m1_axis_tlast  = w_bank_last && w_shadow;
  assign m0_axis_tdata  = s_axis_tdata;
  assign m1_axis_tdata  = s_axis_tdata;
  assign active_bank    = r_active_bank;
  assign active_mode    = r_active_mode;
  assign upload_done    = r_upload_done;

  logic w_unused_cnt;
  assign w_unused_cnt = ^w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_texture_upload_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_texture_upload_ctrl                                   |
// | Description : Self-checking bench for texture_upload_ctrl: a table of  |
// |               upload commands with hand-computed outcomes plus         |
// |               directed reset-abort and early-tlast sequences.          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_texture_upload_ctrl;

  localparam int SW = 16;
`ifdef TEXTURE_LEN_CHECK_EN
  localparam logic LEN_EN = 1'b1;
`else
  localparam logic LEN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [3:0]    cmd_mode;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [SW-1:0] s_axis_tdata;
  logic          m0_axis_tvalid, m0_axis_tlast, m1_axis_tvalid, m1_axis_tlast;
  logic [SW-1:0] m0_axis_tdata, m1_axis_tdata;
  logic          raster_busy;
  logic          active_bank;
  logic [3:0]    active_mode;
  logic          upload_done, err;

  always #5 clk = ~clk;

  texture_upload_ctrl #(.STREAM_WIDTH(SW), .SIZE(14)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
    .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tlast(m0_axis_tlast), .m0_axis_tdata(m0_axis_tdata),
    .m1_axis_tvalid(m1_axis_tvalid), .m1_axis_tlast(m1_axis_tlast), .m1_axis_tdata(m1_axis_tdata),
    .raster_busy(raster_busy), .active_bank(active_bank), .active_mode(active_mode),
    .upload_done(upload_done), .err(err)
  );

  int   errors = 0;
  int   checks = 0;
  logic m_bank = 1'b0;   // bench's own record of the active bank

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] mode;
    int         busy_hold;   // cycles raster_busy stays high after the last beat
    int         exp_beats;   // 0 = command must be rejected
    logic       exp_bank;
    logic [3:0] exp_amode;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int   n_sh, n_oth, n_last, last_pos, n_bad;
    logic sh;
    logic vs, vo, ls, lo;
    logic [SW-1:0] ds;
    n_sh = 0; n_oth = 0; n_last = 0; last_pos = -1; n_bad = 0;
    sh = ~m_bank;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = v.mode;
    #1 chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    if (v.exp_beats == 0) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); cmd_valid = 1'b0;
        #1 if (s_axis_tready || m0_axis_tvalid || m1_axis_tvalid) n_bad++;
      end
      chk("unsup_no_transfer", 32'(n_bad), 32'd0);
      chk("unsup_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("unsup_err", 32'(err), 32'(v.exp_err));
      chk("unsup_bank", 32'(active_bank), 32'(m_bank));
      return;
    end
    for (int i = 0; i < v.exp_beats; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      s_axis_tvalid = 1'b1; s_axis_tdata = i[SW-1:0];
      s_axis_tlast = (i == v.exp_beats - 1);
      raster_busy = i[0];
      #1;
      vs = sh ? m1_axis_tvalid : m0_axis_tvalid;
      vo = sh ? m0_axis_tvalid : m1_axis_tvalid;
      ls = sh ? m1_axis_tlast  : m0_axis_tlast;
      lo = sh ? m0_axis_tlast  : m1_axis_tlast;
      ds = sh ? m1_axis_tdata  : m0_axis_tdata;
      if (!s_axis_tready || lo || ds !== i[SW-1:0] || upload_done) n_bad++;
      if (vs) n_sh++;
      if (vo) n_oth++;
      if (ls) begin n_last++; last_pos = i; end
    end
    chk("shadow_beats", 32'(n_sh), 32'(v.exp_beats));
    chk("other_bank_beats", 32'(n_oth), 32'd0);
    chk("tlast_count", 32'(n_last), 32'd1);
    chk("tlast_position", 32'(last_pos), 32'(v.exp_beats - 1));
    chk("beat_anomalies", 32'(n_bad), 32'd0);
    n_bad = 0;
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; raster_busy = 1'b1;
    repeat (v.busy_hold) begin
      #1 if (upload_done || cmd_ready || s_axis_tready || active_bank !== m_bank) n_bad++;
      @(negedge clk);
    end
    raster_busy = 1'b0;
    #1;
    chk("busy_hold_anomalies", 32'(n_bad), 32'd0);
    chk("no_swap_before_idle", 32'(active_bank), 32'(m_bank));
    chk("cmd_ready_wait_swap", 32'(cmd_ready), 32'd0);
    @(negedge clk); #1;
    chk("upload_done_pulse", 32'(upload_done), 32'd1);
    chk("active_bank_swap", 32'(active_bank), 32'(v.exp_bank));
    chk("active_mode_swap", 32'(active_mode), 32'(v.exp_amode));
    chk("err_after_upload", 32'(err), 32'(v.exp_err));
    m_bank = v.exp_bank;
    @(negedge clk); #1;
    chk("upload_done_single", 32'(upload_done), 32'd0);
    chk("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{mode: 4'b0001, busy_hold: 0,  exp_beats: 1024,  exp_bank: 1'b1, exp_amode: 4'b0001, exp_err: 1'b0};
    vecs[1] = '{mode: 4'b0001, busy_hold: 0,  exp_beats: 1024,  exp_bank: 1'b0, exp_amode: 4'b0001, exp_err: 1'b0};
    vecs[2] = '{mode: 4'b0010, busy_hold: 50, exp_beats: 4096,  exp_bank: 1'b1, exp_amode: 4'b0010, exp_err: 1'b0};
    vecs[3] = '{mode: 4'b1000, busy_hold: 0,  exp_beats: 0,     exp_bank: 1'b1, exp_amode: 4'b0010, exp_err: LEN_EN};
    vecs[4] = '{mode: 4'b0100, busy_hold: 3,  exp_beats: 16384, exp_bank: 1'b0, exp_amode: 4'b0100, exp_err: LEN_EN};
    vecs[5] = '{mode: 4'b0001, busy_hold: 2,  exp_beats: 1024,  exp_bank: 1'b1, exp_amode: 4'b0001, exp_err: LEN_EN};

    reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 4'b0000;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; raster_busy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_active_bank", 32'(active_bank), 32'd0);
    chk("rst_active_mode", 32'(active_mode), 32'd0);
    chk("rst_upload_done", 32'(upload_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bank_valids", 32'({m0_axis_tvalid, m1_axis_tvalid}), 32'd0);
    reset = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k]);

    // Reset in the middle of a load: bank 1 is active, so bank 0 is filling
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = 4'b0001;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = i[SW-1:0];
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_tready", 32'(s_axis_tready), 32'd0);
    chk("abort_active_bank", 32'(active_bank), 32'd0);
    chk("abort_active_mode", 32'(active_mode), 32'd0);
    chk("abort_no_forward", 32'({m0_axis_tvalid, m1_axis_tvalid}), 32'd0);
    chk("abort_upload_done", 32'(upload_done), 32'd0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    #1 chk("abort_upload_done_later", 32'(upload_done), 32'd0);
    m_bank = 1'b0;

    // Upstream tlast on beat 100 of a 32x32 load
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = i[SW-1:0];
      s_axis_tlast = (i == 99);
      #1;
      if (i == 99) begin
        chk("early_beat_valid", 32'(m1_axis_tvalid), 32'd1);
        chk("early_bank_tlast", 32'(m1_axis_tlast), 32'(LEN_EN));
      end
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    #1;
    chk("early_err", 32'(err), 32'(LEN_EN));
    chk("early_cmd_ready", 32'(cmd_ready), 32'(LEN_EN));
    chk("early_tready", 32'(s_axis_tready), 32'(!LEN_EN));
    chk("early_no_swap_bank", 32'(active_bank), 32'd0);
    chk("early_no_done", 32'(upload_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
